// File: rtl/hdmi_config_sequencer.sv
// HDMI transmitter configuration sequencer: debounced hot-plug, power-up wait,
// then a fixed table of I2C register writes with per-entry NACK/timeout retry.
module hdmi_config_sequencer #(
    parameter logic [7:0]  SLAVE_ADDRESS = 8'h72,
    parameter int unsigned POWERUP_DELAY = 250000,
    parameter int unsigned HPD_DEBOUNCE  = 25000,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned RETRY_GAP     = 250,
    parameter int unsigned TIMEOUT       = 4096
) (
    input  logic        clock_25,
    input  logic        reset,
    input  logic        hdmi_hpd,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        i2c_start,
    output logic [7:0]  i2c_slave_address,
    output logic [15:0] i2c_register_data,
    output logic [3:0]  config_index,
    output logic        config_done,
    output logic        config_error
);

    localparam int unsigned PU_W  = (POWERUP_DELAY > 1) ? $clog2(POWERUP_DELAY) : 1;
    localparam int unsigned DB_W  = (HPD_DEBOUNCE > 1) ? $clog2(HPD_DEBOUNCE) : 1;
    localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
    localparam int unsigned RT_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [PU_W-1:0]  PU_LAST    = PU_W'(POWERUP_DELAY - 1);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(HPD_DEBOUNCE - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(RETRY_GAP - 1);
    localparam logic [RT_W-1:0]  RT_MAX     = RT_W'(MAX_RETRIES);
    localparam logic [3:0]       LAST_INDEX = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POWERUP,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_t;

    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    table_entry = 16'h4110;
            4'd1:    table_entry = 16'h9803;
            4'd2:    table_entry = 16'h9AE0;
            4'd3:    table_entry = 16'h9C30;
            4'd4:    table_entry = 16'h9D61;
            4'd5:    table_entry = 16'hA2A4;
            4'd6:    table_entry = 16'hA3A4;
            4'd7:    table_entry = 16'hE0D0;
            4'd8:    table_entry = 16'hF900;
            4'd9:    table_entry = 16'h1500;
            4'd10:   table_entry = 16'h1630;
            4'd11:   table_entry = 16'hAF06;
            default: table_entry = 16'h0000;
        endcase
    endfunction

    logic            hpd_sync1_q;
    logic            hpd_sync2_q;
    logic            hpd_db_q;
    logic            hpd_db_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            hpd_rise;
    logic            hpd_fall;

    state_t             state_q;
    logic [PU_W-1:0]    pu_cnt_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [RT_W-1:0]    retry_q;
    logic [3:0]         index_q;
    logic               start_q;
    logic [7:0]         addr_q;
    logic [15:0]        data_q;
    logic               done_q;
    logic               error_q;
    logic               timed_out;

    always_comb begin
        db_cnt_d = db_cnt_q;
        hpd_db_d = hpd_db_q;
        if (hpd_sync2_q == hpd_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            hpd_db_d = hpd_sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // FSM reacts to the debounced edge on the same clock hpd_db_q updates.
    assign hpd_rise = hpd_db_d & ~hpd_db_q;
    assign hpd_fall = ~hpd_db_d & hpd_db_q;

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            hpd_sync1_q <= 1'b0;
            hpd_sync2_q <= 1'b0;
            hpd_db_q    <= 1'b0;
            db_cnt_q    <= '0;
        end else begin
            hpd_sync1_q <= hdmi_hpd;
            hpd_sync2_q <= hpd_sync1_q;
            hpd_db_q    <= hpd_db_d;
            db_cnt_q    <= db_cnt_d;
        end
    end

    // Timeout window opens on the cycle after the start pulse.
    assign timed_out = ~start_q & (to_cnt_q == TO_LAST);

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pu_cnt_q  <= '0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            retry_q   <= '0;
            index_q   <= '0;
            start_q   <= 1'b0;
            addr_q    <= SLAVE_ADDRESS;
            data_q    <= 16'h4110;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            addr_q  <= SLAVE_ADDRESS;
            if (hpd_fall && state_q != ST_IDLE) begin
                state_q <= ST_IDLE;
                retry_q <= '0;
                index_q <= '0;
                data_q  <= table_entry(4'd0);
                done_q  <= 1'b0;
                error_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (hpd_rise) begin
                            pu_cnt_q <= '0;
                            state_q  <= ST_POWERUP;
                        end
                    end
                    ST_POWERUP: begin
                        if (pu_cnt_q == PU_LAST) begin
                            index_q <= '0;
                            data_q  <= table_entry(4'd0);
                            retry_q <= '0;
                            state_q <= ST_ISSUE;
                        end else begin
                            pu_cnt_q <= pu_cnt_q + 1'b1;
                        end
                    end
                    ST_ISSUE: begin
                        start_q  <= 1'b1;
                        to_cnt_q <= '0;
                        state_q  <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (i2c_done && !i2c_nack) begin
                            if (index_q == LAST_INDEX) begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                index_q <= index_q + 4'd1;
                                data_q  <= table_entry(index_q + 4'd1);
                                retry_q <= '0;
                                state_q <= ST_ISSUE;
                            end
                        end else if (i2c_done || timed_out) begin
                            if (retry_q < RT_MAX) begin
                                retry_q   <= retry_q + 1'b1;
                                gap_cnt_q <= '0;
                                state_q   <= ST_GAP;
                            end else begin
                                error_q <= 1'b1;
                                state_q <= ST_ERROR;
                            end
                        end else if (!start_q) begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt_q == GAP_LAST) begin
                            state_q <= ST_ISSUE;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        done_q <= 1'b1;
                    end
                    ST_ERROR: begin
                        error_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign i2c_start         = start_q;
    assign i2c_slave_address = addr_q;
    assign i2c_register_data = data_q;
    assign config_index      = index_q;
    assign config_done       = done_q;
    assign config_error      = error_q;

endmodule

// File: tb/tb_hdmi_config_sequencer.sv
// Bench for hdmi_config_sequencer: an I2C responder driven from a queue of
// expected transactions (data, index, response mode, start-to-start gap).
module tb_hdmi_config_sequencer;

    localparam int unsigned PU      = 10;
    localparam int unsigned DB      = 4;
    localparam int unsigned MR      = 3;
    localparam int unsigned GAP     = 8;
    localparam int unsigned TMO     = 16;
    localparam int unsigned ACK_DLY = 10;

    localparam int unsigned M_ACK   = 0;
    localparam int unsigned M_NACK  = 1;
    localparam int unsigned M_TMO   = 2;
    localparam int unsigned M_ABORT = 3;

    logic        clock_25;
    logic        reset;
    logic        hdmi_hpd;
    logic        i2c_done;
    logic        i2c_nack;
    logic        i2c_start;
    logic [7:0]  i2c_slave_address;
    logic [15:0] i2c_register_data;
    logic [3:0]  config_index;
    logic        config_done;
    logic        config_error;

    typedef struct {
        logic [15:0] data;
        int unsigned idx;
        int unsigned mode;
        int unsigned dly;
        int unsigned gap;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] tbl [12];
    int unsigned nack_cnt [12];
    int unsigned tmo_cnt [12];
    int unsigned dly_arr [12];
    int          abort_idx;
    int unsigned cyc;
    int unsigned n_cmp;
    int unsigned n_err;

    hdmi_config_sequencer #(
        .SLAVE_ADDRESS(8'h72),
        .POWERUP_DELAY(PU),
        .HPD_DEBOUNCE (DB),
        .MAX_RETRIES  (MR),
        .RETRY_GAP    (GAP),
        .TIMEOUT      (TMO)
    ) dut (
        .clock_25         (clock_25),
        .reset            (reset),
        .hdmi_hpd         (hdmi_hpd),
        .i2c_done         (i2c_done),
        .i2c_nack         (i2c_nack),
        .i2c_start        (i2c_start),
        .i2c_slave_address(i2c_slave_address),
        .i2c_register_data(i2c_register_data),
        .config_index     (config_index),
        .config_done      (config_done),
        .config_error     (config_error)
    );

    initial clock_25 = 1'b0;
    always #5 clock_25 = ~clock_25;

    initial cyc = 0;
    always @(posedge clock_25) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic clear_policy();
        for (int unsigned i = 0; i < 12; i++) begin
            nack_cnt[i] = 0;
            tmo_cnt[i]  = 0;
            dly_arr[i]  = ACK_DLY;
        end
        abort_idx = -1;
    endtask

    // Expected start sequence; gap is measured from the previous start (or
    // from the raw HPD rise for the first one: 2+DB to hpd_db, PU+1 to start).
    task automatic build_expected(output bit expect_error);
        exp_t        e;
        int unsigned gap;
        bit          stop;
        gap = DB + PU + 3;
        expect_error = 1'b0;
        stop = 1'b0;
        exp_q.delete();
        for (int unsigned i = 0; i < 12 && !stop; i++) begin
            for (int unsigned a = 0; a <= MR; a++) begin
                e.data = tbl[i];
                e.idx  = i;
                e.dly  = dly_arr[i];
                e.gap  = gap;
                if (int'(i) == abort_idx)              e.mode = M_ABORT;
                else if (a < tmo_cnt[i])               e.mode = M_TMO;
                else if (a < tmo_cnt[i] + nack_cnt[i]) e.mode = M_NACK;
                else                                   e.mode = M_ACK;
                exp_q.push_back(e);
                case (e.mode)
                    M_ACK:   gap = e.dly + 2;
                    M_NACK:  gap = e.dly + GAP + 2;
                    default: gap = TMO + GAP + 2;
                endcase
                if (e.mode == M_ABORT) begin
                    stop = 1'b1;
                    break;
                end
                if (e.mode == M_ACK) break;
                if (a == MR) begin
                    expect_error = 1'b1;
                    stop = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_start(input int unsigned limit, output bit found, output int unsigned t);
        found = 1'b0;
        t = 0;
        for (int unsigned k = 0; k < limit; k++) begin
            @(negedge clock_25);
            if (i2c_start) begin
                found = 1'b1;
                t = cyc;
                break;
            end
        end
    endtask

    task automatic set_hpd(input logic level, output int unsigned c);
        @(negedge clock_25);
        hdmi_hpd = level;
        c = cyc;
    endtask

    task automatic run_expected(input int unsigned ref_cyc);
        exp_t        e;
        bit          found;
        int unsigned t;
        int unsigned prev;
        prev = ref_cyc;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            wait_start(e.gap + 4, found, t);
            check("start_seen", 32'(found), 1);
            if (!found) begin
                exp_q.delete();
                return;
            end
            check("start_gap", t - prev, e.gap);
            check("reg_data", 32'(i2c_register_data), 32'(e.data));
            check("cfg_index", 32'(config_index), e.idx);
            check("slave_addr", 32'(i2c_slave_address), 32'h72);
            prev = t;
            @(negedge clock_25);
            check("start_pulse", 32'(i2c_start), 0);
            case (e.mode)
                M_ACK, M_NACK: begin
                    repeat (e.dly - 1) @(negedge clock_25);
                    check("data_hold", 32'(i2c_register_data), 32'(e.data));
                    check("done_early", 32'(config_done), 0);
                    i2c_done = 1'b1;
                    i2c_nack = (e.mode == M_NACK);
                    @(negedge clock_25);
                    i2c_done = 1'b0;
                    i2c_nack = 1'b0;
                end
                M_TMO: begin
                    // late ack lands inside the retry gap and must be ignored
                    repeat (TMO + 2) @(negedge clock_25);
                    i2c_done = 1'b1;
                    @(negedge clock_25);
                    i2c_done = 1'b0;
                end
                default: return;
            endcase
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found;
        bit          exp_err;
        int unsigned t;
        int unsigned c;
        tbl = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
                16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'hAF06};
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        hdmi_hpd = 1'b0;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        clear_policy();
        repeat (3) @(negedge clock_25);
        check("rst_start", 32'(i2c_start), 0);
        check("rst_index", 32'(config_index), 0);
        check("rst_done", 32'(config_done), 0);
        check("rst_error", 32'(config_error), 0);
        check("rst_data", 32'(i2c_register_data), 32'h4110);
        check("rst_addr", 32'(i2c_slave_address), 32'h72);
        reset = 1'b0;

        // 3-cycle HPD glitch must be filtered
        set_hpd(1'b1, c);
        repeat (2) @(negedge clock_25);
        set_hpd(1'b0, c);
        wait_start(40, found, t);
        check("glitch_start", 32'(found), 0);
        check("glitch_done", 32'(config_done), 0);

        // Happy path; entry 3 acks on the exact timeout cycle
        clear_policy();
        dly_arr[3] = TMO;
        build_expected(exp_err);
        set_hpd(1'b1, c);
        run_expected(c);
        check("happy_done", 32'(config_done), 32'(!exp_err));
        check("happy_error", 32'(config_error), 32'(exp_err));
        check("happy_index", 32'(config_index), 11);
        wait_start(60, found, t);
        check("happy_no_extra", 32'(found), 0);
        set_hpd(1'b0, c);
        repeat (DB + 4) @(negedge clock_25);
        check("happy_done_clr", 32'(config_done), 0);

        // Timeout on entry 0, two NACKs on entry 5
        clear_policy();
        tmo_cnt[0] = 1;
        nack_cnt[5] = 2;
        build_expected(exp_err);
        set_hpd(1'b1, c);
        run_expected(c);
        check("retry_done", 32'(config_done), 32'(!exp_err));
        check("retry_error", 32'(config_error), 32'(exp_err));
        set_hpd(1'b0, c);
        repeat (DB + 4) @(negedge clock_25);

        // Entry 2 never acknowledges
        clear_policy();
        nack_cnt[2] = MR + 1;
        build_expected(exp_err);
        set_hpd(1'b1, c);
        run_expected(c);
        check("exh_error", 32'(config_error), 32'(exp_err));
        check("exh_done", 32'(config_done), 0);
        check("exh_index", 32'(config_index), 2);
        wait_start(60, found, t);
        check("exh_no_extra", 32'(found), 0);
        check("exh_error_hold", 32'(config_error), 32'(exp_err));
        set_hpd(1'b0, c);
        repeat (DB + 4) @(negedge clock_25);
        check("exh_error_clr", 32'(config_error), 0);

        // HPD dropped while entry 7 is in flight
        clear_policy();
        abort_idx = 7;
        build_expected(exp_err);
        set_hpd(1'b1, c);
        run_expected(c);
        set_hpd(1'b0, c);
        repeat (DB + 4) @(negedge clock_25);
        check("abort_index", 32'(config_index), 0);
        check("abort_data", 32'(i2c_register_data), 32'h4110);
        check("abort_done", 32'(config_done), 0);
        check("abort_error", 32'(config_error), 0);
        @(negedge clock_25);
        i2c_done = 1'b1;
        @(negedge clock_25);
        i2c_done = 1'b0;
        wait_start(40, found, t);
        check("abort_no_start", 32'(found), 0);
        check("abort_index_hold", 32'(config_index), 0);

        // Restart from entry 0, then async reset in WAIT of entry 4
        clear_policy();
        abort_idx = 4;
        build_expected(exp_err);
        set_hpd(1'b1, c);
        run_expected(c);
        #2;
        reset = 1'b1;
        #1;
        check("arst_start", 32'(i2c_start), 0);
        check("arst_index", 32'(config_index), 0);
        check("arst_data", 32'(i2c_register_data), 32'h4110);
        check("arst_done", 32'(config_done), 0);
        check("arst_error", 32'(config_error), 0);
        hdmi_hpd = 1'b0;
        repeat (4) @(negedge clock_25);
        reset = 1'b0;
        wait_start(40, found, t);
        check("post_rst_no_start", 32'(found), 0);
        check("post_rst_index", 32'(config_index), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
